// File: rtl/output_drain_dma.sv
// output_drain_dma: drains one finished output tile from the accumulator's
// drain bank and writes it to memory as AXI4 INCR bursts that never cross a
// 4 KB boundary. Reads are issued against a credit limit so the small
// read-return FIFO can absorb the accumulator's fixed 2-cycle read latency.
//
// Optional feature: define OUTPUT_DRAIN_PERF_EN to build the perf_cycles
// drain-cycle counter; otherwise perf_cycles is tied to 0.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, dst_addr     tile drain request and destination byte address
//   busy, done, error   status: busy span, done pulse, sticky bad-bresp flag
//   perf_cycles         busy cycle count of the last drain
//   acc_dma_ready       accumulator drain bank holds a completed tile
//   acc_rd_en/addr/data accumulator word read port (data 2 cycles after en)
//   m_axi_aw*/w*/b*     AXI4 write master
module output_drain_dma #(
    parameter int unsigned NUM_WORDS  = 25,
    parameter int unsigned ACC_ADDR_W = 10,
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AXI_ADDR_W-1:0] dst_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           perf_cycles,
    input  logic                  acc_dma_ready,
    output logic                  acc_rd_en,
    output logic [ACC_ADDR_W-1:0] acc_rd_addr,
    input  logic [63:0]           acc_rd_data,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [63:0]           m_axi_wdata,
    output logic [7:0]            m_axi_wstrb,
    output logic                  m_axi_wlast,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [1:0]            m_axi_bresp
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam int unsigned LEN_W = 10;

    typedef enum logic [2:0] {IDLE, WAIT_RDY, AW, W, B} state_t;

    state_t                 state, next_state;
    logic                   start_acc, enter_aw, finish, launch;
    logic [AXI_ADDR_W-1:0]  next_addr;
    logic [IDX_W-1:0]       words_left;
    logic [LEN_W-1:0]       beats_left;
    logic [LEN_W-1:0]       burst_len;
    logic [LEN_W-1:0]       words_to_4k;

    logic                   issuing, issue_next;
    logic [IDX_W-1:0]       rd_idx;
    logic                   v0, v1;
    logic [OCC_W-1:0]       occ_next;

    logic [63:0]            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   push, pop, w_fire, b_fire;

    // constant AXI attributes: 8-byte beats, INCR, all lanes
    assign m_axi_awsize  = 3'b011;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = 8'hFF;

    // channel controls decoded from state and FIFO registers
    assign busy          = (state != IDLE);
    assign m_axi_awvalid = (state == AW);
    assign m_axi_wvalid  = (state == W) && (count != '0);
    assign m_axi_wlast   = (state == W) && (beats_left == LEN_W'(1));
    assign m_axi_bready  = (state == B);
    assign m_axi_wdata   = mem[rd_ptr];

    assign w_fire = m_axi_wvalid && m_axi_wready;
    assign b_fire = m_axi_bvalid && m_axi_bready;
    assign push   = v1;
    assign pop    = w_fire;
    assign launch = (state == WAIT_RDY) && acc_dma_ready;

    // next burst length: min of MAX_BURST, words remaining, words to 4 KB
    always_comb begin
        words_to_4k = LEN_W'((13'h1000 - {1'b0, next_addr[11:0]}) >> 3);
        burst_len   = LEN_W'(MAX_BURST);
        if (LEN_W'(words_left) < burst_len) burst_len = LEN_W'(words_left);
        if (words_to_4k < burst_len)        burst_len = words_to_4k;
    end

    // control FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // control FSM next state
    always_comb begin
        next_state = state;
        start_acc  = 1'b0;
        enter_aw   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = WAIT_RDY;
                    start_acc  = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (acc_dma_ready) begin
                    next_state = AW;
                    enter_aw   = 1'b1;
                end
            end
            AW: begin
                if (m_axi_awready) next_state = W;
            end
            W: begin
                if (w_fire && m_axi_wlast) next_state = B;
            end
            B: begin
                if (b_fire) begin
                    if (words_left != '0) begin
                        next_state = AW;
                        enter_aw   = 1'b1;
                    end else begin
                        next_state = IDLE;
                        finish     = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // burst bookkeeping, AW payload and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_addr    <= '0;
            words_left   <= '0;
            beats_left   <= '0;
            m_axi_awaddr <= '0;
            m_axi_awlen  <= '0;
            error        <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= finish;
            if (start_acc) begin
                next_addr  <= dst_addr;
                words_left <= IDX_W'(NUM_WORDS);
                error      <= 1'b0;
            end
            if (enter_aw) begin
                m_axi_awaddr <= next_addr;
                m_axi_awlen  <= 8'(burst_len - LEN_W'(1));
                beats_left   <= burst_len;
                next_addr    <= next_addr + AXI_ADDR_W'({burst_len, 3'b000});
                words_left   <= words_left - IDX_W'(burst_len);
            end
            if (w_fire) beats_left <= beats_left - LEN_W'(1);
            if (b_fire && (m_axi_bresp != 2'b00)) error <= 1'b1;
        end
    end

    // read issuer: next-cycle credit check so acc_rd_en can be a flop.
    // Outstanding after issue = FIFO entries + reads in the 2-cycle pipe.
    always_comb begin
        occ_next   = OCC_W'(count) + OCC_W'(v1) - OCC_W'(pop)
                   + OCC_W'(acc_rd_en) + OCC_W'(v0);
        issue_next = (issuing || launch)
                   && (rd_idx < IDX_W'(NUM_WORDS))
                   && (occ_next < OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issuing     <= 1'b0;
            rd_idx      <= '0;
            acc_rd_en   <= 1'b0;
            acc_rd_addr <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
        end else begin
            v0        <= acc_rd_en;
            v1        <= v0;
            acc_rd_en <= issue_next;
            if (start_acc)   rd_idx  <= '0;
            if (launch)      issuing <= 1'b1;
            else if (finish) issuing <= 1'b0;
            if (issue_next) begin
                acc_rd_addr <= ACC_ADDR_W'(rd_idx);
                rd_idx      <= rd_idx + IDX_W'(1);
            end
        end
    end

    // read-return FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= acc_rd_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef OUTPUT_DRAIN_PERF_EN
    logic [31:0] perf_cnt;

    // busy cycle counter, cleared by an accepted start, held after done
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            perf_cnt <= '0;
        else if (start_acc) perf_cnt <= '0;
        else if (busy)      perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_cycles = perf_cnt;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_output_drain_dma.sv
// Testbench for output_drain_dma: accumulator read model, AXI write slave and
// a scoreboard of expected bursts and beats filled when each start is driven.
module tb_output_drain_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dst_addr;
    logic        busy, done, error;
    logic [31:0] perf_cycles;
    logic        acc_dma_ready;
    logic        acc_rd_en;
    logic [9:0]  acc_rd_addr;
    logic [63:0] acc_rd_data;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [1:0]  m_axi_bresp = 2'b00;

    output_drain_dma dut (
        .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr),
        .busy(busy), .done(done), .error(error), .perf_cycles(perf_cycles),
        .acc_dma_ready(acc_dma_ready), .acc_rd_en(acc_rd_en),
        .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: {awaddr, awlen} per burst and {last, data} per beat
    logic [39:0] aw_q [$];
    logic [64:0] w_q  [$];

    int tile_id   = 0;
    bit rand_mode = 1'b0;
    int bad_burst = -1;

    function automatic logic [63:0] word_of(input int t, input logic [9:0] i);
        return {8'(t) ^ 8'h5A, 14'h0, i, (32'(i) * 32'h9E3779B1) ^ 32'(t)};
    endfunction

    // accumulator read port: data appears exactly 2 cycles after the strobe
    logic [63:0] s1, s2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= acc_rd_en ? word_of(tile_id, acc_rd_addr) : 64'h0;
            s2 <= s1;
        end
    end
    assign acc_rd_data = s2;

    // independent burst model: min(16, remaining, words to next 4 KB)
    task automatic push_expected(input logic [31:0] dst);
        logic [31:0] addr;
        int rem, idx, len, to4k;
        addr = dst;
        rem  = 25;
        idx  = 0;
        while (rem > 0) begin
            to4k = (4096 - int'(addr[11:0])) / 8;
            len  = 16;
            if (rem < len)  len = rem;
            if (to4k < len) len = to4k;
            aw_q.push_back({addr, 8'(len - 1)});
            for (int b = 0; b < len; b++) begin
                w_q.push_back({(b == len - 1), word_of(tile_id, 10'(idx))});
                idx++;
            end
            addr = addr + 32'(8 * len);
            rem  = rem - len;
        end
    endtask

    // monitor and AXI slave, evaluated on the falling edge
    int cyc = 0, seen_tile = -1;
    int issued, popped, rd_idx_exp, resp_idx, b_pending, done_cnt, busy_cycles;
    int first_rd, first_aw, first_wv;

    always @(negedge clk) begin
        logic [39:0] ea;
        logic [64:0] ew;
        bit b_new;
        cyc++;
        b_new = 1'b0;
        if (rst) begin
            issued = 0; popped = 0; rd_idx_exp = 0; resp_idx = 0; b_pending = 0;
            m_axi_bvalid = 1'b0;
            m_axi_awready = 1'b0;
            m_axi_wready = 1'b0;
        end else begin
            if (tile_id != seen_tile) begin
                seen_tile = tile_id;
                issued = 0; popped = 0; rd_idx_exp = 0; resp_idx = 0; b_pending = 0;
                done_cnt = 0; busy_cycles = 0;
                first_rd = -1; first_aw = -1; first_wv = -1;
            end
            m_axi_awready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (acc_rd_en) begin
                check("rd_credit", ((issued - popped) < 4), 1'b1);
                check("rd_addr", acc_rd_addr, 10'(rd_idx_exp));
                if (first_rd < 0) first_rd = cyc;
                rd_idx_exp++;
                issued++;
            end
            if (m_axi_awvalid && first_aw < 0) first_aw = cyc;
            if (m_axi_wvalid && first_wv < 0)  first_wv = cyc;
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_q.size() == 0) check("aw_extra", 1'b1, 1'b0);
                else begin
                    ea = aw_q.pop_front();
                    check("awaddr", m_axi_awaddr, ea[39:8]);
                    check("awlen", m_axi_awlen, ea[7:0]);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_q.size() == 0) check("w_extra", 1'b1, 1'b0);
                else begin
                    ew = w_q.pop_front();
                    check("wdata", m_axi_wdata, ew[63:0]);
                    check("wlast", m_axi_wlast, ew[64]);
                end
                popped++;
                if (m_axi_wlast) b_new = 1'b1;
            end
            m_axi_bvalid = (b_pending > 0);
            m_axi_bresp  = (resp_idx == bad_burst) ? 2'b10 : 2'b00;
            if (m_axi_bvalid && m_axi_bready) begin
                b_pending--;
                resp_idx++;
            end
            if (b_new) b_pending++;
            if (done) begin
                check("busy_at_done", busy, 1'b0);
                done_cnt++;
            end
            if (busy) busy_cycles++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // one full tile drain with scoreboard and end-of-tile checks
    task automatic run_tile(input logic [31:0] dst, input bit rnd, input int bad,
                            input int ready_delay, input bit inject);
        int n;
        tile_id++;
        rand_mode = rnd;
        bad_burst = bad;
        push_expected(dst);
        tick();
        start = 1'b1;
        dst_addr = dst;
        tick();
        check("busy_rise", busy, 1'b1);
        check("error_clear", error, 1'b0);
        for (int i = 0; i < ready_delay; i++) begin
            check("hold_no_req", {acc_rd_en, m_axi_awvalid}, 2'b00);
            tick();
        end
        start = 1'b0;
        acc_dma_ready = 1'b1;
        n = 0;
        while (!acc_rd_en && n < 50) begin tick(); n++; end
        check("first_rd_seen", acc_rd_en, 1'b1);
        acc_dma_ready = 1'b0;
        if (inject) begin
            repeat (3) tick();
            start = 1'b1;
            dst_addr = 32'hDEAD_0000;
            tick();
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 3000) begin tick(); n++; end
        check("done_seen", done_cnt, 1);
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("aw_q_empty", aw_q.size(), 0);
        check("w_q_empty", w_q.size(), 0);
        check("reads_total", issued, 25);
        check("error_flag", error, (bad >= 0));
        check("aw_with_rd", first_aw, first_rd);
        check("wv_latency", ((first_wv - first_rd) >= 3), 1'b1);
`ifdef OUTPUT_DRAIN_PERF_EN
        check("perf_cycles", perf_cycles, busy_cycles);
`else
        check("perf_cycles", perf_cycles, 0);
`endif
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        dst_addr = '0;
        acc_dma_ready = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                           acc_rd_en, busy, done, error}, 8'h00);
        check("rst_const", {m_axi_awsize, m_axi_awburst, m_axi_wstrb}, {3'b011, 2'b01, 8'hFF});
        rst = 1'b0;
        tick();

        // aligned tile, always ready: bursts of 16 and 9
        run_tile(32'h1000_0000, 1'b0, -1, 0, 1'b0);
        // 4 KB split: 2 beats, then bursts starting at 0x1000_1000
        run_tile(32'h1000_0FF0, 1'b0, -1, 0, 1'b0);
        // random awready/wready stalls
        run_tile(32'h2000_0100, 1'b1, -1, 0, 1'b0);
        // SLVERR on the second burst, then a clean tile clears error
        run_tile(32'h2000_0000, 1'b0, 1, 0, 1'b0);
        run_tile(32'h2000_0400, 1'b1, -1, 0, 1'b0);

        // reset in the middle of the first W burst
        tile_id++;
        rand_mode = 1'b0;
        bad_burst = -1;
        push_expected(32'h3000_0000);
        tick();
        start = 1'b1;
        dst_addr = 32'h3000_0000;
        tick();
        start = 1'b0;
        acc_dma_ready = 1'b1;
        n = 0;
        while (!acc_rd_en && n < 50) begin tick(); n++; end
        acc_dma_ready = 1'b0;
        n = 0;
        while (popped < 5 && n < 200) begin tick(); n++; end
        check("mid_w_reached", (popped >= 5), 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid_ctrl", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                              acc_rd_en, busy, done, error}, 8'h00);
        check("rstmid_data", {m_axi_awaddr, m_axi_awlen, m_axi_wdata, acc_rd_addr, perf_cycles}, '0);
        tick();
        check("rstmid_next", {m_axi_awvalid, m_axi_wvalid, acc_rd_en, busy}, 4'h0);
        tick();
        aw_q.delete();
        w_q.delete();
        rst = 1'b0;
        tick();
        run_tile(32'h3000_0000, 1'b0, -1, 0, 1'b0);

        // start held while the accumulator is not ready, plus a start while busy
        run_tile(32'h4000_0F00, 1'b1, -1, 20, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
